// File: rtl/adc_frontend_pkg.sv
// Shared constants for the ADC front-end: sample format and averaging limits.
package adc_frontend_pkg;

    localparam int              ADC_WIDTH    = 10;
    localparam logic [9:0]      ADC_MIDSCALE = 10'h200;
    localparam logic [9:0]      ADC_MAX      = 10'h3FF;
    localparam int              AVG_LOG2_MAX = 4;

endpackage

// File: rtl/adc_boxcar_dec.sv
// Box-car average and decimate by 2^k with round-half-up; k is latched per block.
module adc_boxcar_dec
    import adc_frontend_pkg::*;
#(
    parameter int WIDTH = ADC_WIDTH,
    parameter int KMAX  = AVG_LOG2_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] sample,
    input  logic [2:0]       avg_log2,
    output logic [WIDTH-1:0] x,
    output logic             valid
);

    localparam int AW = WIDTH + KMAX;
    localparam int KW = $clog2(KMAX + 1);
    localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};

    logic [AW-1:0]    acc;
    logic [KMAX-1:0]  phase;
    logic [KW-1:0]    k_active, k_req, k_eff;
    logic [KMAX:0]    n;
    logic [AW:0]      sum, rnd;
    logic             last;
    logic [WIDTH-1:0] x_next;

    // At block start the freshly requested k governs this very sample, so a
    // k=0 block completes with the new value rather than the stale latch.
    always_comb begin
        k_req  = (int'(avg_log2) > KMAX) ? KW'(KMAX) : KW'(avg_log2);
        k_eff  = (phase == '0) ? k_req : k_active;
        n      = (KMAX+1)'(1) << k_eff;
        last   = ({1'b0, phase} == n - (KMAX+1)'(1));
        sum    = {1'b0, acc} + (AW+1)'(sample);
        rnd    = sum + (AW+1)'(n >> 1);
        x_next = WIDTH'(rnd >> k_eff);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            phase    <= '0;
            k_active <= '0;
            x        <= MID;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (en) begin
                if (phase == '0)
                    k_active <= k_req;
                if (last) begin
                    x     <= x_next;
                    valid <= 1'b1;
                    acc   <= '0;
                    phase <= '0;
                end else begin
                    acc   <= sum[AW-1:0];
                    phase <= phase + KMAX'(1);
                end
            end
        end
    end

endmodule

// File: rtl/adc_frontend.sv
// ADC front-end: input register, OTR clamp, box-car decimator, clip and peak statistics.
module adc_frontend
    import adc_frontend_pkg::*;
#(
    parameter int WIDTH        = ADC_WIDTH,
    parameter int AVG_LOG2_MAX = adc_frontend_pkg::AVG_LOG2_MAX,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     i_adc_data,
    input  logic                 i_adc_otr,
    input  logic                 i_en,
    input  logic [2:0]           i_avg_log2,
    input  logic                 i_stat_clr,
    output logic [WIDTH-1:0]     o_x,
    output logic                 o_valid,
    output logic [CNT_WIDTH-1:0] o_clip_cnt,
    output logic [WIDTH-1:0]     o_pk_max,
    output logic [WIDTH-1:0]     o_pk_min
);

    logic [WIDTH-1:0] s1, s;
    logic             otr1, en1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= '0;
            otr1 <= 1'b0;
            en1  <= 1'b0;
        end else begin
            s1   <= i_adc_data;
            otr1 <= i_adc_otr;
            en1  <= i_en;
        end
    end

    // Out-of-range samples rail to the end of the scale the MSB points at.
    always_comb begin
        s = s1;
        if (otr1)
            s = s1[WIDTH-1] ? '1 : '0;
    end

    adc_boxcar_dec #(
        .WIDTH (WIDTH),
        .KMAX  (AVG_LOG2_MAX)
    ) u_boxcar (
        .clk      (clk),
        .reset    (reset),
        .en       (en1),
        .sample   (s),
        .avg_log2 (i_avg_log2),
        .x        (o_x),
        .valid    (o_valid)
    );

    // Clear takes priority: an event in the clearing cycle is not counted.
    always_ff @(posedge clk) begin
        if (reset || i_stat_clr) begin
            o_clip_cnt <= '0;
            o_pk_max   <= '0;
            o_pk_min   <= '1;
        end else begin
            if (en1 && otr1 && (o_clip_cnt != '1))
                o_clip_cnt <= o_clip_cnt + CNT_WIDTH'(1);
            if (o_valid) begin
                if (o_x > o_pk_max) o_pk_max <= o_x;
                if (o_x < o_pk_min) o_pk_min <= o_x;
            end
        end
    end

endmodule

// File: tb/tb_adc_frontend.sv
// Directed bench for adc_frontend: latency, averaging, clamp, clip saturation, k latching, stat clear.
module tb_adc_frontend;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  adc_data = 10'h0AB;
    logic        adc_otr = 1'b0;
    logic        en = 1'b1;
    logic [2:0]  avg_log2 = 3'd0;
    logic        stat_clr = 1'b0;
    logic [9:0]  x, pk_max, pk_min;
    logic        valid;
    logic [15:0] clip_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int c0;
    logic [9:0] vq[$];
    int         vc[$];

    adc_frontend dut (
        .clk        (clk),
        .reset      (reset),
        .i_adc_data (adc_data),
        .i_adc_otr  (adc_otr),
        .i_en       (en),
        .i_avg_log2 (avg_log2),
        .i_stat_clr (stat_clr),
        .o_x        (x),
        .o_valid    (valid),
        .o_clip_cnt (clip_cnt),
        .o_pk_max   (pk_max),
        .o_pk_min   (pk_min)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every output update with the cycle it appeared in.
    always @(negedge clk) begin
        if (valid) begin
            vq.push_back(x);
            vc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [9:0] d, input logic otr, input logic e);
        adc_data = d;
        adc_otr  = otr;
        en       = e;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(10'h000, 1'b0, 1'b0);
    endtask

    task automatic clr_q();
        vq.delete();
        vc.delete();
    endtask

    task automatic chk_blk(input string tag, input logic [9:0] exp_x, input int exp_cyc);
        chk({tag, "_cnt"}, vq.size(), 1);
        if (vq.size() > 0) begin
            chk({tag, "_x"}, vq[0], exp_x);
            chk({tag, "_cyc"}, vc[0], exp_cyc);
        end
        clr_q();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_x", x, 10'h200);
        chk("rst_valid", valid, 0);
        chk("rst_clip", clip_cnt, 0);
        chk("rst_pkmin", pk_min, 10'h3FF);
        chk("rst_pkmax", pk_max, 0);

        // k=0: first update two clocks after reset release
        reset = 1'b0;
        tick();
        chk("lat_early", valid, 0);
        tick();
        chk("lat_valid", valid, 1);
        chk("lat_x", x, 10'h0AB);
        idle(3);
        chk("pk0_max", pk_max, 10'h0AB);
        chk("pk0_min", pk_min, 10'h0AB);

        // k=2, ramp 0x100..0x103 twice
        avg_log2 = 3'd2;
        idle(2);
        clr_q();
        c0 = cyc;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) drive(10'h100 + 10'(i), 1'b0, 1'b1);
        idle(4);
        chk("k2_cnt", vq.size(), 2);
        if (vq.size() == 2) begin
            chk("k2_x0", vq[0], 10'h102);
            chk("k2_x1", vq[1], 10'h102);
            chk("k2_cyc0", vc[0], c0 + 5);
            chk("k2_gap", vc[1] - vc[0], 4);
        end
        clr_q();
        chk("pk2_max", pk_max, 10'h102);
        chk("pk2_min", pk_min, 10'h0AB);

        // OTR clamp inside a k=2 block; a disabled OTR sample is not counted
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        drive(10'h3F0, 1'b1, 1'b0);
        clr_q();
        c0 = cyc;
        drive(10'h3F0, 1'b1, 1'b1);
        drive(10'h010, 1'b1, 1'b1);
        drive(10'h100, 1'b0, 1'b1);
        drive(10'h100, 1'b0, 1'b1);
        idle(4);
        chk_blk("otr_avg", 10'h180, c0 + 5);
        chk("otr_clip", clip_cnt, 2);
        chk("otr_pkmax", pk_max, 10'h180);
        chk("otr_pkmin", pk_min, 10'h180);

        // clip counter saturation
        avg_log2 = 3'd0;
        idle(2);
        for (int i = 0; i < 65540; i++) drive(10'h3F0, 1'b1, 1'b1);
        idle(3);
        chk("clip_sat", clip_cnt, 16'hFFFF);
        chk("sat_pkmax", pk_max, 10'h3FF);
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        chk("clr_clip", clip_cnt, 0);
        chk("clr_pkmax", pk_max, 0);
        chk("clr_pkmin", pk_min, 10'h3FF);
        clr_q();

        // k=3, contiguous block then one with a 5-cycle enable gap
        avg_log2 = 3'd3;
        idle(2);
        clr_q();
        c0 = cyc;
        for (int i = 1; i <= 8; i++) drive(10'(i * 16), 1'b0, 1'b1);
        idle(4);
        chk_blk("k3_nogap", 10'h048, c0 + 9);
        c0 = cyc;
        repeat (3) drive(10'h200, 1'b0, 1'b1);
        idle(5);
        repeat (4) drive(10'h200, 1'b0, 1'b1);
        drive(10'h207, 1'b0, 1'b1);
        idle(4);
        chk_blk("k3_gap", 10'h201, c0 + 14);

        // k changes 1->3 on the second sample of a k=1 block
        avg_log2 = 3'd1;
        idle(2);
        clr_q();
        c0 = cyc;
        drive(10'h100, 1'b0, 1'b1);
        drive(10'h103, 1'b0, 1'b1);
        avg_log2 = 3'd3;
        repeat (8) drive(10'h300, 1'b0, 1'b1);
        idle(4);
        chk("kchg_cnt", vq.size(), 2);
        if (vq.size() == 2) begin
            chk("kchg_x0", vq[0], 10'h102);
            chk("kchg_cyc0", vc[0], c0 + 3);
            chk("kchg_x1", vq[1], 10'h300);
            chk("kchg_cyc1", vc[1], c0 + 11);
        end
        clr_q();

        // k request 7 behaves as k=4; full-scale input must not overflow
        avg_log2 = 3'd7;
        idle(2);
        clr_q();
        c0 = cyc;
        repeat (16) drive(10'h3FF, 1'b0, 1'b1);
        idle(4);
        chk_blk("k7_full", 10'h3FF, c0 + 17);
        c0 = cyc;
        repeat (15) drive(10'h3FF, 1'b0, 1'b1);
        drive(10'h3F0, 1'b0, 1'b1);
        idle(4);
        chk_blk("k7_round", 10'h3FE, c0 + 17);

        // clear coincident with an update: that update is excluded
        avg_log2 = 3'd0;
        idle(2);
        drive(10'h3FF, 1'b0, 1'b1);
        drive(10'h000, 1'b0, 1'b0);
        chk("clrv_valid", valid, 1);
        chk("clrv_x", x, 10'h3FF);
        stat_clr = 1'b1;
        drive(10'h000, 1'b0, 1'b0);
        stat_clr = 1'b0;
        chk("clrv_pkmax", pk_max, 0);
        chk("clrv_pkmin", pk_min, 10'h3FF);
        chk("clrv_xhold", x, 10'h3FF);
        drive(10'h250, 1'b0, 1'b1);
        idle(3);
        chk("post_pkmax", pk_max, 10'h250);
        chk("post_pkmin", pk_min, 10'h250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
